sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
- Shares the single-port SRAM port (req/we/addr/be/wdata, 1-cycle rdata) between NumPorts requesters, e.g. the AXI-to-memory bridge, a preload/backdoor loader and a debug reader.
- Round-robin grant with optional bounded lock for multi-beat bursts.
- Routes the read-return valid to the port that was granted on the previous cycle.
- Sits between the requesters and the SRAM.

Parameters:
- NumPorts, 2: number of requesters; must be ≥2.
- AddrWidth, 64: address width.
- DataWidth, 64: data width; byte-enable width is DataWidth/8.
- MaxLock, 16: maximum consecutive locked grants to one port before a forced rotation; must be ≥1.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- m_req_i  in  NumPorts  per-port request
- m_we_i  in  NumPorts  per-port write enable
- m_lock_i  in  NumPorts  hold the grant after this access
- m_addr_i  in  NumPorts×AddrWidth  per-port address
- m_be_i  in  NumPorts×DataWidth/8  per-port byte enable
- m_wdata_i  in  NumPorts×DataWidth  per-port write data
- m_gnt_o  out  NumPorts  one-hot grant; the access is accepted this cycle
- m_rvalid_o  out  NumPorts  one-hot response valid, one cycle after the grant
- m_rdata_o  out  DataWidth  read data broadcast to all ports
- req_o  out  1  SRAM request
- we_o  out  1  SRAM write enable
- addr_o  out  AddrWidth  SRAM address
- be_o  out  DataWidth/8  SRAM byte enable
- wdata_o  out  DataWidth  SRAM write data
- rdata_i  in  DataWidth  SRAM read data, valid one cycle after req_o

Behaviour:
- Reset: the state is cleared asynchronously.
  - rr_ptr=0, lock_owner invalid, lock_cnt=0, resp_port invalid.
  - m_rvalid_o=0.
  - m_gnt_o and req_o are combinational, but are 0 while rst_i is high.
- Grant is combinational in the same cycle.
  - With no lock active, the winner is the first requesting port at or after rr_ptr, searching cyclically.
  - m_gnt_o[w]=1 and req_o=1.
  - we_o, addr_o, be_o, wdata_o are muxed from port w.
  - With no request: req_o=0, m_gnt_o=0, and the data outputs are 0.
- rr_ptr update: on every grant, rr_ptr<=(w+1) mod NumPorts; it is unchanged on idle cycles.
- Lock, state IDLE/LOCKED:
  - IDLE→LOCKED when the granted port w has m_lock_i[w]=1 and MaxLock>1. Then lock_owner<=w and lock_cnt<=1.
  - In LOCKED, if m_req_i[owner]=1 the owner is granted regardless of rr_ptr, and lock_cnt is incremented.
  - LOCKED→IDLE when the owner is granted with m_lock_i=0, or lock_cnt reaches MaxLock after the grant (forced release), or the owner has no request (that cycle falls back to round-robin among the others).
  - On a forced release, rr_ptr is set past the owner so that the other ports win next.
- Response: resp_port<=w (valid) on a grant, for both reads and writes.
  - Next cycle, m_rvalid_o[resp_port]=1 and m_rdata_o=rdata_i.
  - For writes, m_rdata_o is don't-care; rvalid serves as the write acknowledgement.
- Back-to-back grants give one rvalid per cycle. There is no internal buffering and no backpressure on the response side.
- A requester must hold req/addr/we/be/wdata stable until it sees gnt.
- Reset mid-operation: any pending response is dropped (no rvalid) and the lock is cleared.
- The grant logic uses a double-width priority scan or a rotate-then-priority-encode. The cyclic index wraps from NumPorts-1 to 0.

Decomposition:
- Shared package sram_arb_pkg holds:
  - the localparam for the port-index width $clog2(NumPorts);
  - the typedef sram_req_t {we, addr, be, wdata};
  - the typedef lock_state_e {IDLE, LOCKED}.
- One sub-module rr_prio_sel (NumPorts): combinational, inputs are the request vector and pointer; outputs are the one-hot winner, the index, and valid.
- Lock FSM, counter and response pipeline stay in the top module.

Test Plan:
- Single port: port0 reads addr 0x80 (SRAM preloaded with 0xDEAD_BEEF) → gnt0 in cycle 0, req_o=1 and addr_o=0x80 in cycle 0, rvalid0=1 and m_rdata_o=0xDEAD_BEEF in cycle 1, no rvalid on other ports.
- Fairness: NumPorts=2, both requesting continuously for 8 cycles from reset → grants alternate 0,1,0,1,…; 4 grants each; rvalid follows each grant by exactly 1 cycle.
- Lock: MaxLock=4, port1 requests with lock=1 while port0 also requests → port1 gets 4 consecutive grants, then port0 is granted on the 5th cycle.
- Lock release: port1 is locked, drops lock on its 2nd beat → port0 is granted on the 3rd cycle.
- Write then read: port0 writes 0x1122334455667788 with be=0x0F to 0x100, then reads 0x100 → rvalid after each access; read data equals 0x0000000055667788 when the SRAM was initialised to 0.
- Reset mid-operation: assert rst_i in the cycle after a grant → no rvalid appears, rr_ptr=0, and the first grant after reset goes to port0 when all ports request.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types for the SRAM port arbiter.
// Request bundle fields are sized for the widest supported port.
package sram_arb_pkg;

    localparam int unsigned NumPortsDef = 2;
    localparam int unsigned PortIdxW    = $clog2(NumPortsDef);

    localparam int unsigned SramAddrW = 64;
    localparam int unsigned SramDataW = 64;
    localparam int unsigned SramBeW   = SramDataW / 8;

    typedef struct packed {
        logic                 we;
        logic [SramAddrW-1:0] addr;
        logic [SramBeW-1:0]   be;
        logic [SramDataW-1:0] wdata;
    } sram_req_t;

    typedef enum logic {
        IDLE,
        LOCKED
    } lock_state_e;

    function automatic int unsigned port_idx_w(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sram_port_arbiter_rr_sel.sv
// Cyclic priority select: first requester at or after ptr wins.
module rr_prio_sel
    import sram_arb_pkg::*;
#(
    parameter int unsigned NumPorts = 2
) (
    input  logic [NumPorts-1:0]               req,
    input  logic [port_idx_w(NumPorts)-1:0]   ptr,
    output logic [NumPorts-1:0]               onehot,
    output logic [port_idx_w(NumPorts)-1:0]   idx,
    output logic                              valid
);

    localparam int unsigned IdxW = port_idx_w(NumPorts);

    int unsigned j;

    always_comb begin
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        j      = 0;
        for (int i = 0; i < int'(NumPorts); i++) begin
            j = (int'(ptr) + i) % NumPorts;
            if (!valid && req[j]) begin
                valid     = 1'b1;
                idx       = IdxW'(j);
                onehot[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Round-robin SRAM port arbiter with bounded burst lock.
// Read-return valid is routed to the port granted one cycle earlier.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned NumPorts  = 2,
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned MaxLock   = 16
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [NumPorts-1:0]                  m_req_i,
    input  logic [NumPorts-1:0]                  m_we_i,
    input  logic [NumPorts-1:0]                  m_lock_i,
    input  logic [NumPorts-1:0][AddrWidth-1:0]   m_addr_i,
    input  logic [NumPorts-1:0][DataWidth/8-1:0] m_be_i,
    input  logic [NumPorts-1:0][DataWidth-1:0]   m_wdata_i,
    output logic [NumPorts-1:0]                  m_gnt_o,
    output logic [NumPorts-1:0]                  m_rvalid_o,
    output logic [DataWidth-1:0]                 m_rdata_o,
    output logic                                 req_o,
    output logic                                 we_o,
    output logic [AddrWidth-1:0]                 addr_o,
    output logic [DataWidth/8-1:0]               be_o,
    output logic [DataWidth-1:0]                 wdata_o,
    input  logic [DataWidth-1:0]                 rdata_i
);

    localparam int unsigned IdxW = port_idx_w(NumPorts);
    localparam int unsigned CntW = $clog2(MaxLock + 1);

    lock_state_e         state, state_n;
    logic [IdxW-1:0]     rr_ptr, rr_ptr_n;
    logic [IdxW-1:0]     lock_owner, lock_owner_n;
    logic [CntW-1:0]     lock_cnt, lock_cnt_n;
    logic                resp_vld;
    logic [IdxW-1:0]     resp_port;

    logic [NumPorts-1:0] rr_onehot;
    logic [IdxW-1:0]     rr_idx;
    logic                rr_valid;
    logic                owner_req;
    logic                gnt_any;
    logic [IdxW-1:0]     win;
    logic [IdxW-1:0]     win_next;
    sram_req_t           sel;

    rr_prio_sel #(
        .NumPorts(NumPorts)
    ) u_rr_sel (
        .req   (m_req_i),
        .ptr   (rr_ptr),
        .onehot(rr_onehot),
        .idx   (rr_idx),
        .valid (rr_valid)
    );

    assign owner_req = (state == LOCKED) && m_req_i[lock_owner];
    assign gnt_any   = !rst_i && (owner_req || rr_valid);
    assign win       = owner_req ? lock_owner : rr_idx;
    assign win_next  = (win == IdxW'(NumPorts - 1)) ? '0 : win + 1'b1;

    always_comb begin
        m_gnt_o = '0;
        if (!rst_i) begin
            if (owner_req) m_gnt_o[lock_owner] = 1'b1;
            else           m_gnt_o = rr_onehot;
        end
    end

    // Fields wider than the port are zero-filled, then cut back below.
    always_comb begin
        sel = '0;
        if (gnt_any) begin
            sel.we    = m_we_i[win];
            sel.addr  = SramAddrW'(m_addr_i[win]);
            sel.be    = SramBeW'(m_be_i[win]);
            sel.wdata = SramDataW'(m_wdata_i[win]);
        end
    end

    assign req_o   = gnt_any;
    assign we_o    = sel.we;
    assign addr_o  = sel.addr[AddrWidth-1:0];
    assign be_o    = sel.be[DataWidth/8-1:0];
    assign wdata_o = sel.wdata[DataWidth-1:0];

    always_comb begin
        state_n      = state;
        rr_ptr_n     = rr_ptr;
        lock_owner_n = lock_owner;
        lock_cnt_n   = lock_cnt;
        if (gnt_any) rr_ptr_n = win_next;
        if (owner_req) begin
            if (!m_lock_i[win]) begin
                state_n    = IDLE;
                lock_cnt_n = '0;
            end else if (int'(lock_cnt) + 1 >= int'(MaxLock)) begin
                state_n    = IDLE;
                lock_cnt_n = '0;
            end else begin
                lock_cnt_n = lock_cnt + 1'b1;
            end
        end else begin
            // Owner absent: this cycle is arbitrated as if unlocked.
            state_n    = IDLE;
            lock_cnt_n = '0;
            if (gnt_any && m_lock_i[win] && MaxLock > 1) begin
                state_n      = LOCKED;
                lock_owner_n = win;
                lock_cnt_n   = CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            lock_owner <= '0;
            lock_cnt   <= '0;
            resp_vld   <= 1'b0;
            resp_port  <= '0;
        end else begin
            state      <= state_n;
            rr_ptr     <= rr_ptr_n;
            lock_owner <= lock_owner_n;
            lock_cnt   <= lock_cnt_n;
            resp_vld   <= gnt_any;
            if (gnt_any) resp_port <= win;
        end
    end

    always_comb begin
        m_rvalid_o = '0;
        if (resp_vld) m_rvalid_o[resp_port] = 1'b1;
    end

    assign m_rdata_o = rdata_i;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: vector table for grants plus a
// response scoreboard checked against an SRAM model.
module tb_sram_port_arbiter;

    localparam int N  = 2;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int BW = DW / 8;
    localparam int ML = 4;

    localparam logic [AW-1:0] A0 = 64'h80;
    localparam logic [AW-1:0] A1 = 64'h88;
    localparam logic [DW-1:0] D0 = 64'hDEAD_BEEF;
    localparam logic [DW-1:0] D1 = 64'hCAFE_F00D;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N-1:0]         m_req, m_we, m_lock, m_gnt, m_rvalid;
    logic [N-1:0][AW-1:0] m_addr;
    logic [N-1:0][BW-1:0] m_be;
    logic [N-1:0][DW-1:0] m_wdata;
    logic [DW-1:0]        m_rdata, wdata, rdata;
    logic                 req, we;
    logic [AW-1:0]        addr;
    logic [BW-1:0]        be;

    sram_port_arbiter #(
        .NumPorts(N), .AddrWidth(AW), .DataWidth(DW), .MaxLock(ML)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .m_req_i(m_req), .m_we_i(m_we), .m_lock_i(m_lock),
        .m_addr_i(m_addr), .m_be_i(m_be), .m_wdata_i(m_wdata),
        .m_gnt_o(m_gnt), .m_rvalid_o(m_rvalid), .m_rdata_o(m_rdata),
        .req_o(req), .we_o(we), .addr_o(addr), .be_o(be),
        .wdata_o(wdata), .rdata_i(rdata)
    );

    logic [DW-1:0] mem [64];

    initial begin
        for (int i = 0; i < 64; i++) mem[i] <= '0;
        mem[16] <= D0;
        mem[17] <= D1;
    end

    always @(posedge clk) begin
        if (req) begin
            if (we) begin
                for (int b = 0; b < BW; b++)
                    if (be[b]) mem[addr[8:3]][b*8 +: 8] <= wdata[b*8 +: 8];
            end
            rdata <= mem[addr[8:3]];
        end
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc++;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        int          port;
        bit          chk_data;
        logic [63:0] data;
        int          due;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    always @(negedge clk) begin
        if (!rst) begin
            while (sb.size() > 0 && sb[0].due < cyc) begin
                e = sb.pop_front();
                chk("missing_rvalid", 64'(m_rvalid), 64'(1 << e.port));
            end
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                chk("rvalid", 64'(m_rvalid), 64'(1 << e.port));
                if (e.chk_data) chk("rdata", m_rdata, e.data);
            end else begin
                chk("no_rvalid", 64'(m_rvalid), 64'(0));
            end
        end
    end

    typedef struct {
        bit         rst;
        logic [1:0] req;
        logic [1:0] lock;
        logic [1:0] gnt;
    } vec_t;

    vec_t vt[$];

    task automatic do_reset();
        @(posedge clk); #1;
        m_req  = '0;
        m_lock = '0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [AW-1:0] ea;
        rst     = 1'b1;
        m_req   = '0;
        m_we    = '0;
        m_lock  = '0;
        m_addr[0] = A0;
        m_addr[1] = A1;
        m_be    = '1;
        m_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        m_req = 2'b11;
        #1;
        chk("rst_gnt", 64'(m_gnt), 64'(0));
        chk("rst_req", 64'(req), 64'(0));
        chk("rst_rvalid", 64'(m_rvalid), 64'(0));
        m_req = '0;
        rst   = 1'b0;

        vt.push_back('{1'b1, 2'b01, 2'b00, 2'b01});
        vt.push_back('{1'b0, 2'b00, 2'b00, 2'b00});
        vt.push_back('{1'b1, 2'b11, 2'b00, 2'b01});
        for (int i = 0; i < 7; i++)
            vt.push_back('{1'b0, 2'b11, 2'b00, (i % 2 == 0) ? 2'b10 : 2'b01});
        vt.push_back('{1'b0, 2'b10, 2'b10, 2'b10});
        for (int i = 0; i < 3; i++)
            vt.push_back('{1'b0, 2'b11, 2'b10, 2'b10});
        vt.push_back('{1'b0, 2'b11, 2'b00, 2'b01});
        vt.push_back('{1'b0, 2'b10, 2'b10, 2'b10});
        vt.push_back('{1'b0, 2'b11, 2'b00, 2'b10});
        vt.push_back('{1'b0, 2'b11, 2'b00, 2'b01});
        vt.push_back('{1'b0, 2'b10, 2'b10, 2'b10});
        vt.push_back('{1'b0, 2'b01, 2'b01, 2'b01});
        vt.push_back('{1'b0, 2'b11, 2'b00, 2'b01});
        vt.push_back('{1'b0, 2'b11, 2'b00, 2'b10});

        foreach (vt[k]) begin
            if (vt[k].rst) do_reset();
            @(posedge clk); #1;
            m_req  = vt[k].req;
            m_lock = vt[k].lock;
            #1;
            ea = (vt[k].gnt == 2'b01) ? A0 : (vt[k].gnt == 2'b10) ? A1 : '0;
            chk($sformatf("gnt[%0d]", k), 64'(m_gnt), 64'(vt[k].gnt));
            chk($sformatf("req[%0d]", k), 64'(req), 64'(|vt[k].gnt));
            chk($sformatf("addr[%0d]", k), addr, ea);
            if (vt[k].gnt != 2'b00)
                sb.push_back('{vt[k].gnt[1] ? 1 : 0, 1'b1,
                               vt[k].gnt[1] ? D1 : D0, cyc + 1});
        end

        @(posedge clk); #1;
        m_req     = 2'b01;
        m_lock    = '0;
        m_we      = 2'b01;
        m_addr[0] = 64'h100;
        m_be[0]   = 8'h0F;
        m_wdata[0] = 64'h1122_3344_5566_7788;
        #1;
        chk("wr_gnt", 64'(m_gnt), 64'(2'b01));
        chk("wr_we", 64'(we), 64'(1));
        chk("wr_addr", addr, 64'h100);
        chk("wr_be", 64'(be), 64'h0F);
        chk("wr_wdata", wdata, 64'h1122_3344_5566_7788);
        sb.push_back('{0, 1'b0, 64'h0, cyc + 1});

        @(posedge clk); #1;
        m_we = '0;
        #1;
        chk("rd_gnt", 64'(m_gnt), 64'(2'b01));
        chk("rd_we", 64'(we), 64'(0));
        sb.push_back('{0, 1'b1, 64'h0000_0000_5566_7788, cyc + 1});

        @(posedge clk); #1;
        m_req = '0;
        #1;
        chk("idle_req", 64'(req), 64'(0));
        chk("idle_addr", addr, 64'h0);
        chk("idle_wdata", wdata, 64'h0);
        chk("idle_be", 64'(be), 64'h0);

        @(posedge clk); #1;
        m_addr[0] = A0;
        m_be[0]   = '1;
        m_req     = 2'b10;
        m_lock    = 2'b10;
        #1;
        chk("pre_rst_gnt", 64'(m_gnt), 64'(2'b10));

        @(posedge clk); #1;
        rst    = 1'b1;
        m_req  = 2'b11;
        m_lock = '0;
        #1;
        chk("mid_rst_rvalid", 64'(m_rvalid), 64'(0));
        chk("mid_rst_gnt", 64'(m_gnt), 64'(0));

        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("post_rst_gnt", 64'(m_gnt), 64'(2'b01));
        chk("post_rst_addr", addr, A0);
        sb.push_back('{0, 1'b1, D0, cyc + 1});

        @(posedge clk); #1;
        m_req = '0;
        @(posedge clk); #1;
        chk("sb_empty", 64'(sb.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
